// File: rtl/nibble_serial_compare_if.sv
// Signal bundle between the nibble sequencer, its requester and the HC85 stage.
interface nibble_serial_compare_if #(
    parameter int WIDTH = 16
);
    localparam int CNTW = $clog2(WIDTH / 4) + 1;

    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [2:0]       cmp_in;
    logic             busy;
    logic             done;
    logic [2:0]       result;
    logic             err;
    logic [CNTW-1:0]  nib_cnt;

    modport master (
        output start, a_in, b_in, cmp_in,
        input  nib_a, nib_b, busy, done, result, err, nib_cnt
    );

    modport slave (
        input  start, a_in, b_in, cmp_in,
        output nib_a, nib_b, busy, done, result, err, nib_cnt
    );
endinterface

// File: rtl/nibble_serial_compare.sv
// Serial WIDTH-bit magnitude compare using one external 4-bit HC85 stage.
// Nibble pairs go out MSB first; the {gt,eq,lt} answer is folded into result.
//
// state  | meaning
// S_IDLE | waiting for start; result/err hold the last verdict
// S_RUN  | one nibble pair on nib_a/nib_b per clock, cmp_in sampled at the edge
// S_DONE | one-clock done pulse, then back to S_IDLE
module nibble_serial_compare #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    nibble_serial_compare_if.slave bus
);
    localparam int NNIB = WIDTH / 4;
    localparam int IDXW = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam int CNTW = $clog2(NNIB) + 1;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [2:0]       result_q, result_d;
    logic             err_q, err_d;
    // First non-eq nibble verdict, kept when the scan continues past it.
    logic [2:0]       rec_q, rec_d;
    logic             rec_vld_q, rec_vld_d;

    logic             cmp_onehot;
    logic             cmp_neq;
    logic [3:0]       sel_a;
    logic [3:0]       sel_b;

    assign sel_a      = a_q[int'(idx_q) * 4 +: 4];
    assign sel_b      = b_q[int'(idx_q) * 4 +: 4];
    assign cmp_onehot = (bus.cmp_in == CMP_GT) || (bus.cmp_in == CMP_EQ) ||
                        (bus.cmp_in == CMP_LT);
    assign cmp_neq    = (bus.cmp_in != CMP_EQ);

    assign bus.nib_a   = (state_q == S_RUN) ? sel_a : 4'h0;
    assign bus.nib_b   = (state_q == S_RUN) ? sel_b : 4'h0;
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.result  = result_q;
    assign bus.err     = err_q;
    assign bus.nib_cnt = cnt_q;

    // State and datapath registers; reset aborts any scan without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            result_q  <= 3'b000;
            err_q     <= 1'b0;
            rec_q     <= 3'b000;
            rec_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            err_q     <= err_d;
            rec_q     <= rec_d;
            rec_vld_q <= rec_vld_d;
        end
    end

    // Next-state and verdict folding; an invalid comparator code always ends the scan.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        err_d     = err_q;
        rec_d     = rec_q;
        rec_vld_d = rec_vld_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d       = bus.a_in;
                    b_d       = bus.b_in;
                    idx_d     = IDXW'(NNIB - 1);
                    cnt_d     = '0;
                    rec_vld_d = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNTW'(1);
                if (!cmp_onehot) begin
                    result_d = 3'b000;
                    err_d    = 1'b1;
                    state_d  = S_DONE;
                end else if (cmp_neq && EARLY_EXIT) begin
                    result_d = bus.cmp_in;
                    err_d    = 1'b0;
                    state_d  = S_DONE;
                end else begin
                    if (cmp_neq && !rec_vld_q) begin
                        rec_d     = bus.cmp_in;
                        rec_vld_d = 1'b1;
                    end
                    if (idx_q == '0) begin
                        result_d = rec_vld_q ? rec_q : bus.cmp_in;
                        err_d    = 1'b0;
                        state_d  = S_DONE;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
